spike_decoder: RTL and testbench
================================

SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 Parameter CNT_W, default 8: width of spike count, ISI and window length.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 spike_in  input  1  spike train from a QIF neuron spike output; level, any duration.
REQ-005 enable  input  1  1 = decode, 0 = stop and return to IDLE.
REQ-006 win_len  input  CNT_W  window length in cycles; 0 means 2^CNT_W.
REQ-007 rate_out  output  CNT_W  spikes counted in the last completed window.
REQ-008 isi_out  output  CNT_W  cycles between the two most recent spike edges.
REQ-009 out_valid  output  1  rate_out/isi_out hold an unconsumed result.
REQ-010 out_ready  input  1  consumer accepts the result when out_valid=1.
REQ-011 overrun  output  1  sticky: a completed window result was dropped.

Function
REQ-012 A spike event SHALL be a rising edge of spike_in, detected against a registered copy; one event per edge regardless of pulse width.
REQ-013 States SHALL be IDLE, COUNT, WRAP; IDLE->COUNT when enable=1; COUNT->WRAP on last window cycle; WRAP->COUNT next cycle (enable=1) or ->IDLE (enable=0); any state->IDLE when enable=0.
REQ-014 win_len SHALL be sampled on entry to COUNT; changes mid-window SHALL take effect from the next window.
REQ-015 Window cycle counter SHALL count from 1 to sampled length; a spike event on the last window cycle SHALL belong to that window.
REQ-016 Window spike count SHALL saturate at 2^CNT_W-1.
REQ-017 In WRAP the count SHALL be offered to the output register and the window counter/spike count cleared; a spike event during WRAP SHALL count in the next window.
REQ-018 Latency: out_valid SHALL rise one cycle after WRAP, i.e. two cycles after the last window cycle.
REQ-019 Handshake: transfer occurs on a cycle with out_valid=1 and out_ready=1; out_valid SHALL fall the following cycle unless a new result loads that same cycle.
REQ-020 Output register SHALL load when out_valid=0, or when out_valid=1 and out_ready=1 in the load cycle; otherwise the new result SHALL be dropped, outputs unchanged, overrun set.
REQ-021 rate_out/isi_out SHALL be stable while out_valid=1 and not accepted.
REQ-022 ISI counter SHALL increment every cycle while enable=1, saturate at 2^CNT_W-1, and on a spike event latch its value (plus 1) into an internal ISI register and restart at 0; isi_out SHALL load from that register with rate_out.
REQ-023 ISI before the first spike after reset SHALL read 2^CNT_W-1 (saturated).
REQ-024 enable=0 mid-window SHALL discard the partial count; output register, out_valid and overrun SHALL be preserved.
REQ-025 overrun SHALL clear only on reset.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, rate_out 0, isi_out 0, out_valid 0, overrun 0, all counters 0, registered spike copy 0, ISI counter saturated.
REQ-027 Reset mid-window SHALL discard all partial results; first window after release starts on the first enable=1 cycle.

Structure
REQ-028 Shared package qif_pkg SHALL hold the state enum (IDLE/COUNT/WRAP) and the default CNT_W constant.
REQ-029 One sub-module spike_edge_detect (register + rising-edge pulse) SHALL be instantiated; all else in spike_decoder.

Verification
REQ-030 win_len=10, spike_in 1-cycle pulses every 3 cycles, out_ready=1 -> rate_out=3 or 4 per window per phase, isi_out=3, out_valid 1 cycle per window.
REQ-031 spike_in held high 20 cycles, win_len=32 -> rate_out=1 (single edge).
REQ-032 out_ready=0, win_len=8, two windows -> first result held, out_valid stays 1, overrun=1 after second WRAP.
REQ-033 win_len=0, spike every cycle-pair -> window 256 cycles, rate_out=255 saturated? no: 128 expected; with pulses every cycle edge impossible, so toggle spike_in each cycle -> rate_out=128.
REQ-034 Spike on last window cycle (win_len=5, spike at cycle 5) -> counted, rate_out=1; spike in WRAP cycle -> next window rate_out=1.
REQ-035 rst_n low mid-window with out_valid=1, overrun=1 -> all outputs 0 same cycle, no clock required.

Source files
------------

// File: rtl/qif_pkg.sv
// Shared definitions for the QIF spike decoding path.
//   - CNT_W_DEFAULT : default width of spike count, ISI and window length
//   - dec_state_e   : window sequencing states (idle, counting, window wrap-up)
package qif_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCount = 2'd1,
        StWrap  = 2'd2
    } dec_state_e;

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for a level spike train.
//   clk        : clock
//   rst_n      : asynchronous active-low reset (registered copy cleared to 0)
//   spike_in   : spike level input, any pulse width
//   spike_edge : one-cycle pulse when spike_in is high and was low last cycle
module spike_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic spike_in,
    output logic spike_edge
);

    logic spike_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike_in;
        end
    end

    assign spike_edge = spike_in & ~spike_q;

endmodule

// File: rtl/spike_decoder.sv
// Rate and inter-spike-interval decoder for a QIF neuron spike train.
// Counts spike edges over a programmable window and tracks the interval
// between the two most recent edges; each completed window is offered to a
// valid/ready output register.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   spike_in  : spike level input
//   enable    : 1 = decode, 0 = stop and return to idle
//   win_len   : window length in cycles, 0 means 2^CNT_W
//   rate_out  : spikes counted in the last completed window
//   isi_out   : cycles between the two most recent spike edges
//   out_valid : rate_out/isi_out hold an unconsumed result
//   out_ready : consumer accepts the result while out_valid=1
//   overrun   : sticky, a completed window result was dropped
module spike_decoder
    import qif_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_in,
    input  logic             enable,
    input  logic [CNT_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic [CNT_W-1:0] isi_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic spike_edge;

    spike_edge_detect u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .spike_edge (spike_edge)
    );

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
    logic [CNT_W-1:0] isi_cnt_q, isi_cnt_d;
    logic [CNT_W-1:0] isi_reg_q, isi_reg_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic [CNT_W-1:0] isi_out_q, isi_out_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic last_cycle;
    logic load_req;
    logic load;

    // win_cnt holds the index of the current window cycle (1..len). A zero
    // length wraps the counter back to 0 after 2^CNT_W cycles, which then
    // matches len_q = 0 without needing an extra counter bit.
    assign last_cycle = (win_cnt_q == len_q);

    // Window sequencing and spike counting
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        win_cnt_d = win_cnt_q;
        spk_cnt_d = spk_cnt_q;
        load_req  = 1'b0;

        case (state_q)
            StIdle: begin
                win_cnt_d = '0;
                spk_cnt_d = '0;
                if (enable) begin
                    state_d   = StCount;
                    len_d     = win_len;
                    win_cnt_d = CntOne;
                end
            end

            StCount: begin
                if (!enable) begin
                    // Partial window is discarded
                    state_d   = StIdle;
                    win_cnt_d = '0;
                    spk_cnt_d = '0;
                end else begin
                    if (spike_edge && (spk_cnt_q != CntMax)) begin
                        spk_cnt_d = spk_cnt_q + CntOne;
                    end
                    if (last_cycle) begin
                        state_d   = StWrap;
                        win_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + CntOne;
                    end
                end
            end

            StWrap: begin
                // The window is already complete, so its result is offered
                // even if enable drops during this cycle.
                load_req = 1'b1;
                if (enable) begin
                    state_d   = StCount;
                    len_d     = win_len;
                    win_cnt_d = CntOne;
                    // An edge seen while wrapping up belongs to the new window
                    spk_cnt_d = spike_edge ? CntOne : '0;
                end else begin
                    state_d   = StIdle;
                    win_cnt_d = '0;
                    spk_cnt_d = '0;
                end
            end

            default: begin
                state_d   = StIdle;
                win_cnt_d = '0;
                spk_cnt_d = '0;
            end
        endcase
    end

    // Inter-spike interval tracking; runs independently of window state
    always_comb begin
        isi_cnt_d = isi_cnt_q;
        isi_reg_d = isi_reg_q;
        if (enable) begin
            if (spike_edge) begin
                isi_reg_d = (isi_cnt_q == CntMax) ? CntMax : isi_cnt_q + CntOne;
                isi_cnt_d = '0;
            end else if (isi_cnt_q != CntMax) begin
                isi_cnt_d = isi_cnt_q + CntOne;
            end
        end
    end

    // Output register with valid/ready handshake
    assign load = load_req && (!valid_q || out_ready);

    always_comb begin
        rate_d    = rate_q;
        isi_out_d = isi_out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            rate_d    = spk_cnt_q;
            isi_out_d = isi_reg_q;
            valid_d   = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load_req && !load) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            len_q     <= '0;
            win_cnt_q <= '0;
            spk_cnt_q <= '0;
            isi_cnt_q <= CntMax;
            isi_reg_q <= CntMax;
            rate_q    <= '0;
            isi_out_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            win_cnt_q <= win_cnt_d;
            spk_cnt_q <= spk_cnt_d;
            isi_cnt_q <= isi_cnt_d;
            isi_reg_q <= isi_reg_d;
            rate_q    <= rate_d;
            isi_out_q <= isi_out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rate_out  = rate_q;
    assign isi_out   = isi_out_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_decoder.sv
module tb_spike_decoder;

    localparam int unsigned W    = 8;
    localparam int          MAXV = 255;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         spike_in = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] win_len = '0;
    logic         out_ready = 1'b0;
    logic [W-1:0] rate_out;
    logic [W-1:0] isi_out;
    logic         out_valid;
    logic         overrun;

    always #5 clk = ~clk;

    spike_decoder #(.CNT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spike_in  (spike_in),
        .enable    (enable),
        .win_len   (win_len),
        .rate_out  (rate_out),
        .isi_out   (isi_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: windows are tracked by the absolute cycle number of
    // the next wrap; ISI is the distance between edge timestamps measured in
    // enabled cycles.
    int cyc_n;
    bit m_prev;
    bit m_run;
    int m_next_wrap;
    int m_cnt;
    int m_ts;
    int m_last_ts;
    bit m_have_last;
    int m_isi_reg;
    int e_rate, e_isi;
    bit e_valid, e_ovr;

    task automatic model_reset();
        m_prev = 0; m_run = 0; m_next_wrap = 0; m_cnt = 0;
        m_ts = 0; m_last_ts = 0; m_have_last = 0; m_isi_reg = MAXV;
        e_rate = 0; e_isi = 0; e_valid = 0; e_ovr = 0;
    endtask

    task automatic model_step(input bit en, input bit spk, input bit rdy, input int wl);
        bit ev;
        bit emit;
        int r_rate, r_isi, len, d;
        ev     = spk && !m_prev;
        m_prev = spk;
        emit   = 0;
        r_rate = 0;
        r_isi  = 0;
        len    = (wl == 0) ? 256 : wl;
        if (m_run) begin
            if (cyc_n == m_next_wrap) begin
                emit   = 1;
                r_rate = (m_cnt > MAXV) ? MAXV : m_cnt;
                r_isi  = m_isi_reg;
                if (en) begin
                    m_cnt       = ev ? 1 : 0;
                    m_next_wrap = cyc_n + len + 1;
                end else begin
                    m_run = 0;
                end
            end else if (!en) begin
                m_run = 0;
            end else if (ev) begin
                m_cnt++;
            end
        end else if (en) begin
            m_run       = 1;
            m_cnt       = 0;
            m_next_wrap = cyc_n + len + 1;
        end
        if (en) begin
            m_ts++;
            if (ev) begin
                d = m_ts - m_last_ts;
                m_isi_reg   = (m_have_last && d < MAXV) ? d : MAXV;
                m_last_ts   = m_ts;
                m_have_last = 1;
            end
        end
        if (emit) begin
            if (!e_valid || rdy) begin
                e_rate  = r_rate;
                e_isi   = r_isi;
                e_valid = 1;
            end else begin
                e_ovr = 1;
            end
        end else if (e_valid && rdy) begin
            e_valid = 0;
        end
        cyc_n++;
    endtask

    task automatic compare_all();
        check_eq("rate_out", rate_out, e_rate);
        check_eq("isi_out", isi_out, e_isi);
        check_eq("out_valid", out_valid, e_valid);
        check_eq("overrun", overrun, e_ovr);
    endtask

    // One clock cycle: drive inputs, let the DUT sample, compare #1 later
    task automatic cyc(input bit en, input bit spk, input bit rdy, input int wl);
        enable    = en;
        spike_in  = spk;
        out_ready = rdy;
        win_len   = wl[W-1:0];
        @(posedge clk);
        model_step(en, spk, rdy, wl);
        #1;
        compare_all();
    endtask

    int seen[$];

    initial begin
        bit en_r;
        cyc_n = 0;
        model_reset();

        // Reset state
        #12;
        check_eq("rst_rate", rate_out, 0);
        check_eq("rst_isi", isi_out, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        // Pulses every 3 cycles, window 10
        for (int i = 0; i < 80; i++) begin
            cyc(1, (i % 3) == 0, 1, 10);
            if (out_valid) begin
                check_eq("isi_3", isi_out, 3);
                check_eq("rate_3or4", (rate_out == 3 || rate_out == 4) ? 1 : 0, 1);
            end
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 10);

        // Long pulse counts as a single edge
        seen.delete();
        for (int i = 0; i < 41; i++) begin
            cyc(1, (i >= 3 && i < 23), 1, 32);
            if (out_valid) seen.push_back(int'(rate_out));
        end
        check_eq("long_pulse_nres", seen.size() > 0 ? 1 : 0, 1);
        if (seen.size() > 0) check_eq("long_pulse_rate", seen[0], 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32);

        // Edge on last window cycle, then edge in the wrap cycle
        seen.delete();
        for (int i = 0; i < 21; i++) begin
            cyc(1, (i == 5 || i == 12), 1, 5);
            if (out_valid) seen.push_back(int'(rate_out));
        end
        check_eq("lastcyc_nres", seen.size() >= 3 ? 1 : 0, 1);
        if (seen.size() >= 3) begin
            check_eq("lastcyc_w0", seen[0], 1);
            check_eq("lastcyc_w1", seen[1], 0);
            check_eq("lastcyc_w2", seen[2], 1);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 5);

        // Zero length = 256-cycle window, spike toggling every cycle
        seen.delete();
        for (int i = 0; i < 300; i++) begin
            cyc(1, i[0], 1, 0);
            if (out_valid) seen.push_back(int'(rate_out));
        end
        check_eq("win256_nres", seen.size() > 0 ? 1 : 0, 1);
        if (seen.size() > 0) check_eq("win256_rate", seen[0], 128);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

        // Consumer stalled over two windows
        for (int i = 0; i < 23; i++) cyc(1, (i == 2 || i == 4 || i == 12), 0, 8);
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_overrun", overrun, 1);
        check_eq("stall_rate_held", rate_out, 2);

        // Asynchronous reset mid-window, no clock edge involved
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rate", rate_out, 0);
        check_eq("arst_isi", isi_out, 0);
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_overrun", overrun, 0);
        model_reset();
        #2;
        rst_n = 1'b1;

        // Randomised traffic
        en_r = 1;
        for (int i = 0; i < 3000; i++) begin
            int wl;
            if (en_r && $urandom_range(0, 79) == 0) en_r = 0;
            else if (!en_r && $urandom_range(0, 3) == 0) en_r = 1;
            wl = ($urandom_range(0, 49) == 0) ? 0 : int'($urandom_range(1, 12));
            cyc(en_r, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, wl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
